// File: rtl/pow2_frac_eval.sv
// ----------------------------------------------------------------------------
// pow2_frac_eval
//
// Antilog mantissa evaluator. Given a fractional exponent f in [0,1), returns
// 2^f in [1,2) as Q1.7. Exponent bits are consumed MSB first, one per clock.
// For every set bit k the accumulator is multiplied by C_k = 2^(2^-k).
//
// Ports:
//   clk       in   1       clock, rising edge
//   rst       in   1       asynchronous active-low reset
//   start     in   1       request, sampled only while idle
//   frac_in   in   FRAC_W  fractional exponent, Q0.FRAC_W, captured with start
//   busy      out  1       evaluation in progress
//   done      out  1       one-cycle pulse, mant_out has just been updated
//   mant_out  out  8       2^f as Q1.7, held until the next done
//
// FRAC_W is legal from 1 to 8 because the constant table holds eight entries.
// ----------------------------------------------------------------------------
module pow2_frac_eval #(
    parameter int FRAC_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [FRAC_W-1:0] frac_in,
    output logic              busy,
    output logic              done,
    output logic [7:0]        mant_out
);

    typedef enum logic {
        IDLE = 1'b0,
        EVAL = 1'b1
    } state_t;

    localparam int              CNT_W    = (FRAC_W > 1) ? $clog2(FRAC_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAC_W - 1);

    // C_k = 2^(2^-k) in Q1.7, rounded to nearest; idx = k-1.
    function automatic logic [7:0] c_rom(input logic [2:0] idx);
        case (idx)
            3'd0:    c_rom = 8'd181;
            3'd1:    c_rom = 8'd152;
            3'd2:    c_rom = 8'd140;
            3'd3:    c_rom = 8'd134;
            3'd4:    c_rom = 8'd131;
            3'd5:    c_rom = 8'd129;
            3'd6:    c_rom = 8'd129;
            default: c_rom = 8'd128;
        endcase
    endfunction

    state_t            state, state_next;
    logic [FRAC_W-1:0] shreg;
    logic [7:0]        acc;
    logic [CNT_W-1:0]  cnt;

    logic              load;
    logic              step;
    logic              last;

    logic [2:0]        rom_idx;
    logic [15:0]       prod;
    logic [7:0]        acc_next;
    logic              unused_prod_lsbs;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so
    // every register samples the values from before the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: the default assignment first keeps this combinational block
    // from inferring a latch on any path that forgets to assign.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load) state_next = EVAL;
            EVAL:    if (last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / control decode (busy and done themselves are registered)
    // ------------------------------------------------------------------
    always_comb begin
        load = 1'b0;
        step = 1'b0;
        last = 1'b0;
        case (state)
            IDLE: load = start;
            EVAL: begin
                step = 1'b1;
                last = (cnt == LAST_CNT);
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Multiply step: the current exponent bit is always the shift MSB, and
    // the counter selects the matching constant.
    // ------------------------------------------------------------------
    assign rom_idx = 3'(cnt);
    assign prod    = 16'(acc) * 16'(c_rom(rom_idx));

    // Truncation discards the low product bits on purpose.
    assign unused_prod_lsbs = ^prod[6:0];

    always_comb begin
        acc_next = acc;
        if (shreg[FRAC_W-1]) begin
            acc_next = prod[15] ? 8'hFF : prod[14:7];
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg    <= '0;
            acc      <= 8'h80;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            mant_out <= 8'h80;
        end else begin
            done <= 1'b0;
            if (load) begin
                shreg <= frac_in;
                acc   <= 8'h80;
                cnt   <= '0;
                busy  <= 1'b1;
            end else if (step) begin
                shreg <= shreg << 1;
                acc   <= acc_next;
                cnt   <= cnt + CNT_W'(1);
                if (last) begin
                    mant_out <= acc_next;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                end
            end
        end
    end

endmodule
